id_pipe_stage: RTL and testbench

//  Registered instruction-decode stage for the pipelined 16-bit processor.

---
 rtl/id_pipe_stage_pkg.sv | 37 +++
 rtl/id_decode_comb.sv | 68 ++++++
 rtl/id_pipe_stage.sv | 88 ++++++++
 tb/tb_id_pipe_stage.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/id_pipe_stage_pkg.sv
// id_pipe_stage_pkg: opcodes, ALU func codes, ctl bit indices and halt FSM states for the decode stage.
package id_pipe_stage_pkg;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDZ = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_NOR  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SRA  = 4'h7;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_LHB  = 4'hA;
  localparam logic [3:0] OP_LLB  = 4'hB;
  localparam logic [3:0] OP_B    = 4'hC;
  localparam logic [3:0] OP_JAL  = 4'hD;
  localparam logic [3:0] OP_JR   = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;
  localparam logic [2:0] F_ADD = 3'b000;
  localparam logic [2:0] F_SUB = 3'b001;
  localparam logic [2:0] F_AND = 3'b010;
  localparam logic [2:0] F_NOR = 3'b011;
  localparam logic [2:0] F_SLL = 3'b100;
  localparam logic [2:0] F_SRL = 3'b101;
  localparam logic [2:0] F_LHB = 3'b110;
  localparam logic [2:0] F_SRA = 3'b111;
  localparam int CTL_BR   = 8;
  localparam int CTL_JAL  = 7;
  localparam int CTL_JR   = 6;
  localparam int CTL_ADDZ = 5;
  localparam int CTL_WE   = 4;
  localparam int CTL_SRC1 = 3;
  localparam int CTL_WMEM = 2;
  localparam int CTL_RMEM = 1;
  localparam int CTL_WB   = 0;
  typedef enum logic [1:0] {RUN, HALT_WAIT, HALTED} state_t;
endpackage

// File: rtl/id_decode_comb.sv
// id_decode_comb: pure combinational decode of one 16-bit instruction into the EX bundle.
module id_decode_comb
  import id_pipe_stage_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int REG_AW   = 4,
  parameter int IMM_W    = 8,
  parameter int BR_OFF_W = 9
) (
  input  logic [15:0]       instr,
  output logic [REG_AW-1:0] p0,
  output logic [REG_AW-1:0] p1,
  output logic [REG_AW-1:0] dst,
  output logic [2:0]        func,
  output logic [3:0]        shamt,
  output logic [IMM_W-1:0]  imm,
  output logic [DATA_W-1:0] br_off,
  output logic [2:0]        br_cond,
  output logic [8:0]        ctl,
  output logic              reads_p0,
  output logic              reads_p1,
  output logic              is_hlt
);
  logic [3:0] op;
  logic rr, sh, lw, sw, lhb, llb;
  always_comb begin
    op  = instr[15:12];
    rr  = op inside {OP_ADD, OP_ADDZ, OP_SUB, OP_AND, OP_NOR};
    sh  = op inside {OP_SLL, OP_SRL, OP_SRA};
    lw  = op == OP_LW;
    sw  = op == OP_SW;
    lhb = op == OP_LHB;
    llb = op == OP_LLB;
    is_hlt   = op == OP_HLT;
    reads_p0 = !(op inside {OP_LLB, OP_B, OP_JAL, OP_HLT});
    reads_p1 = rr | sw;
    // reg-reg ops read rt at [3:0]; lhb merges into rd; everything else reads rs at [7:4]
    p0  = rr ? REG_AW'(instr[3:0]) : lhb ? REG_AW'(instr[11:8]) : REG_AW'(instr[7:4]);
    p1  = sw ? REG_AW'(instr[11:8]) : REG_AW'(instr[7:4]);
    dst = op == OP_JAL ? REG_AW'(4'hF) : REG_AW'(instr[11:8]);
    func = F_ADD;
    case (op)
      OP_SUB: func = F_SUB;
      OP_AND: func = F_AND;
      OP_NOR: func = F_NOR;
      OP_SLL: func = F_SLL;
      OP_SRL: func = F_SRL;
      OP_SRA: func = F_SRA;
      OP_LHB: func = F_LHB;
      default: func = F_ADD;
    endcase
    shamt   = sh ? instr[3:0] : 4'h0;
    imm     = (lw | sw) ? IMM_W'($signed(instr[3:0])) : (lhb | llb) ? IMM_W'(instr[7:0]) : '0;
    br_off  = op == OP_B ? DATA_W'($signed(instr[BR_OFF_W-1:0]))
            : op == OP_JAL ? DATA_W'($signed(instr[11:0])) : '0;
    br_cond = instr[11:9];
    ctl = '0;
    ctl[CTL_BR]   = op == OP_B;
    ctl[CTL_JAL]  = op == OP_JAL;
    ctl[CTL_JR]   = op == OP_JR;
    ctl[CTL_ADDZ] = op == OP_ADDZ;
    ctl[CTL_WE]   = !(op inside {OP_B, OP_JR, OP_SW, OP_HLT});
    ctl[CTL_SRC1] = sh | lw | sw | lhb | llb;
    ctl[CTL_WMEM] = sw;
    ctl[CTL_RMEM] = lw;
    ctl[CTL_WB]   = lw;
  end
endmodule

// File: rtl/id_pipe_stage.sv
// id_pipe_stage: registered decode stage with valid/ready handshake, load-use interlock,
// flush and a RUN/HALT_WAIT/HALTED freeze FSM.
module id_pipe_stage
  import id_pipe_stage_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int IMM_W    = 8,
  parameter int BR_OFF_W = 9,
  localparam int REG_AW  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [15:0]       if_instr,
  input  logic [DATA_W-1:0] if_pc,
  output logic              id_ready,
  input  logic              ex_ready,
  input  logic              flush,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_pc,
  output logic [REG_AW-1:0] p0_addr,
  output logic [REG_AW-1:0] p1_addr,
  output logic [REG_AW-1:0] dst_addr,
  output logic [2:0]        func,
  output logic [3:0]        shamt,
  output logic [IMM_W-1:0]  imm,
  output logic [DATA_W-1:0] br_off,
  output logic [2:0]        br_cond,
  output logic [8:0]        ctl,
  output logic              halted
);
  state_t state, nxt;
  logic [REG_AW-1:0] d_p0, d_p1, d_dst;
  logic [2:0] d_func, d_cond;
  logic [3:0] d_shamt;
  logic [IMM_W-1:0] d_imm;
  logic [DATA_W-1:0] d_off;
  logic [8:0] d_ctl;
  logic d_rp0, d_rp1, d_hlt, hazard, xfer;
  id_decode_comb #(.DATA_W(DATA_W), .REG_AW(REG_AW), .IMM_W(IMM_W), .BR_OFF_W(BR_OFF_W)) u_dec (
    .instr(if_instr), .p0(d_p0), .p1(d_p1), .dst(d_dst), .func(d_func), .shamt(d_shamt),
    .imm(d_imm), .br_off(d_off), .br_cond(d_cond), .ctl(d_ctl),
    .reads_p0(d_rp0), .reads_p1(d_rp1), .is_hlt(d_hlt)
  );
  always_comb begin
    hazard   = id_valid & ctl[CTL_RMEM] & if_valid &
               ((d_rp0 & d_p0 == dst_addr) | (d_rp1 & d_p1 == dst_addr));
    id_ready = !rst & state == RUN & !hazard & !flush & (!id_valid | ex_ready);
    xfer     = if_valid & id_ready;
    nxt = state;
    if (flush) nxt = state == HALT_WAIT ? RUN : state;
    else if (state == RUN && xfer && d_hlt) nxt = HALT_WAIT;
    else if (state == HALT_WAIT && ex_ready) nxt = HALTED;
  end
  assign halted = state == HALTED;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      id_valid <= 1'b0;
      id_pc    <= '0;
      p0_addr  <= '0;
      p1_addr  <= '0;
      dst_addr <= '0;
      func     <= '0;
      shamt    <= '0;
      imm      <= '0;
      br_off   <= '0;
      br_cond  <= '0;
      ctl      <= '0;
    end else begin
      state    <= nxt;
      id_valid <= flush ? 1'b0 : (!id_valid | ex_ready) ? xfer : id_valid;
      if (xfer) begin
        id_pc    <= if_pc;
        p0_addr  <= d_p0;
        p1_addr  <= d_p1;
        dst_addr <= d_dst;
        func     <= d_func;
        shamt    <= d_shamt;
        imm      <= d_imm;
        br_off   <= d_off;
        br_cond  <= d_cond;
        ctl      <= d_ctl;
      end
    end
  end
endmodule

// File: tb/tb_id_pipe_stage.sv
// tb_id_pipe_stage: directed scenario tasks for the decode stage with hand-computed expectations.
module tb_id_pipe_stage;
  logic clk = 1'b0;
  logic rst, if_valid, ex_ready, flush, id_ready, id_valid, halted;
  logic [15:0] if_instr, if_pc, id_pc, br_off;
  logic [3:0] p0_addr, p1_addr, dst_addr, shamt;
  logic [2:0] func, br_cond;
  logic [7:0] imm;
  logic [8:0] ctl;
  int checks = 0;
  int errors = 0;

  id_pipe_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .ex_ready(ex_ready), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .p0_addr(p0_addr), .p1_addr(p1_addr), .dst_addr(dst_addr),
    .func(func), .shamt(shamt), .imm(imm), .br_off(br_off), .br_cond(br_cond),
    .ctl(ctl), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1; if_valid = 0; if_instr = 16'h0; if_pc = 16'h0; ex_ready = 1; flush = 0;
    step; step;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", id_valid); end
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", id_ready); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b want 0", halted); end
    checks++; if ({ctl, dst_addr, br_off} !== 29'h0) begin errors++; $display("FAIL rst_bundle got %h want 0", {ctl, dst_addr, br_off}); end
    rst = 0; #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b want 1", id_ready); end
  endtask

  task automatic test_add;
    if_valid = 1; if_instr = 16'h0123; if_pc = 16'h0010; ex_ready = 1;
    step;
    if_valid = 0;
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b want 1", id_valid); end
    checks++; if ({dst_addr, p1_addr, p0_addr} !== 12'h123) begin errors++; $display("FAIL add_regs got %h want 123", {dst_addr, p1_addr, p0_addr}); end
    checks++; if (func !== 3'b000) begin errors++; $display("FAIL add_func got %b want 000", func); end
    checks++; if (ctl !== 9'h010) begin errors++; $display("FAIL add_ctl got %h want 010", ctl); end
    checks++; if (id_pc !== 16'h0010) begin errors++; $display("FAIL add_pc got %h want 0010", id_pc); end
    step;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL add_drain got %b want 0", id_valid); end
  endtask

  task automatic test_backpressure;
    ex_ready = 0; if_valid = 1; if_instr = 16'h2456; if_pc = 16'h0012;
    step;
    if_instr = 16'h3789; if_pc = 16'h0014;
    for (int i = 0; i < 3; i++) begin
      checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b want 0", i, id_ready); end
      checks++; if ({id_valid, dst_addr, func, p0_addr, id_pc} !== {1'b1, 4'h4, 3'b001, 4'h6, 16'h0012})
        begin errors++; $display("FAIL bp_hold[%0d] got %h want %h", i, {id_valid, dst_addr, func, p0_addr, id_pc}, {1'b1, 4'h4, 3'b001, 4'h6, 16'h0012}); end
      step;
    end
    ex_ready = 1; #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b want 1", id_ready); end
    step;
    if_valid = 0;
    checks++; if ({id_valid, dst_addr, p1_addr, p0_addr, func} !== {1'b1, 12'h789, 3'b010})
      begin errors++; $display("FAIL bp_next got %h want %h", {id_valid, dst_addr, p1_addr, p0_addr, func}, {1'b1, 12'h789, 3'b010}); end
    step;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", id_valid); end
  endtask

  task automatic test_load_use;
    ex_ready = 1; if_valid = 1; if_instr = 16'h8452; if_pc = 16'h0020;
    step;
    checks++; if ({ctl, imm, dst_addr, p0_addr} !== {9'h01B, 8'h02, 4'h4, 4'h5})
      begin errors++; $display("FAIL lw_bundle got %h want %h", {ctl, imm, dst_addr, p0_addr}, {9'h01B, 8'h02, 4'h4, 4'h5}); end
    if_instr = 16'h0641; #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL lu_stall got %b want 0", id_ready); end
    step;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got %b want 0", id_valid); end
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL lu_ready got %b want 1", id_ready); end
    step;
    checks++; if ({id_valid, dst_addr, p1_addr, p0_addr} !== {1'b1, 12'h641})
      begin errors++; $display("FAIL lu_issue got %h want %h", {id_valid, dst_addr, p1_addr, p0_addr}, {1'b1, 12'h641}); end
    if_instr = 16'h8452; step;
    if_instr = 16'h0623; #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL lu_nohaz got %b want 1", id_ready); end
    step;
    if_instr = 16'h8452; step;
    if_instr = 16'h9420; #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL lu_sw_stall got %b want 0", id_ready); end
    step; step;
    if_valid = 0;
    checks++; if ({id_valid, ctl, p1_addr, p0_addr, imm} !== {1'b1, 9'h00C, 4'h4, 4'h2, 8'h00})
      begin errors++; $display("FAIL lu_sw got %h want %h", {id_valid, ctl, p1_addr, p0_addr, imm}, {1'b1, 9'h00C, 4'h4, 4'h2, 8'h00}); end
    step;
  endtask

  task automatic test_branch;
    ex_ready = 1; if_valid = 1; if_instr = 16'hCFFE; if_pc = 16'h0030;
    step;
    checks++; if ({br_off, ctl, br_cond} !== {16'hFFFE, 9'h100, 3'b111})
      begin errors++; $display("FAIL br_bundle got %h want %h", {br_off, ctl, br_cond}, {16'hFFFE, 9'h100, 3'b111}); end
    if_instr = 16'hD7FF; if_pc = 16'h0032;
    step;
    checks++; if ({br_off, ctl, dst_addr} !== {16'h07FF, 9'h090, 4'hF})
      begin errors++; $display("FAIL jal_bundle got %h want %h", {br_off, ctl, dst_addr}, {16'h07FF, 9'h090, 4'hF}); end
    if_instr = 16'h0123; flush = 1; #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", id_ready); end
    step;
    flush = 0; if_valid = 0;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_kill got %b want 0", id_valid); end
  endtask

  task automatic test_back_to_back;
    ex_ready = 1; if_valid = 1; if_instr = 16'h5125; if_pc = 16'h0040;
    step;
    checks++; if ({func, shamt, p0_addr, ctl} !== {3'b100, 4'h5, 4'h2, 9'h018})
      begin errors++; $display("FAIL b2b_sll got %h want %h", {func, shamt, p0_addr, ctl}, {3'b100, 4'h5, 4'h2, 9'h018}); end
    if_instr = 16'hB39A; if_pc = 16'h0042;
    step;
    checks++; if ({id_valid, imm, shamt, dst_addr, ctl, id_pc} !== {1'b1, 8'h9A, 4'h0, 4'h3, 9'h018, 16'h0042})
      begin errors++; $display("FAIL b2b_llb got %h want %h", {id_valid, imm, shamt, dst_addr, ctl, id_pc}, {1'b1, 8'h9A, 4'h0, 4'h3, 9'h018, 16'h0042}); end
    if_instr = 16'h1ABC; if_pc = 16'h0044;
    step;
    if_valid = 0;
    checks++; if ({id_valid, dst_addr, p1_addr, p0_addr, ctl} !== {1'b1, 12'hABC, 9'h030})
      begin errors++; $display("FAIL b2b_addz got %h want %h", {id_valid, dst_addr, p1_addr, p0_addr, ctl}, {1'b1, 12'hABC, 9'h030}); end
    step;
  endtask

  task automatic test_halt_flush;
    ex_ready = 0; if_valid = 1; if_instr = 16'hF000; if_pc = 16'h0050;
    step;
    if_valid = 0;
    checks++; if ({id_valid, id_ready, halted, ctl} !== {3'b100, 9'h000})
      begin errors++; $display("FAIL hf_wait got %h want %h", {id_valid, id_ready, halted, ctl}, {3'b100, 9'h000}); end
    flush = 1;
    step;
    flush = 0; #1;
    checks++; if ({id_valid, halted, id_ready} !== 3'b001)
      begin errors++; $display("FAIL hf_run got %b want 001", {id_valid, halted, id_ready}); end
    ex_ready = 1;
  endtask

  task automatic test_halt;
    ex_ready = 1; if_valid = 1; if_instr = 16'hF000; if_pc = 16'h0060;
    step;
    if_instr = 16'h0123;
    checks++; if ({id_valid, id_ready, halted} !== 3'b100)
      begin errors++; $display("FAIL halt_wait got %b want 100", {id_valid, id_ready, halted}); end
    step;
    checks++; if ({id_valid, halted} !== 2'b01) begin errors++; $display("FAIL halt_enter got %b want 01", {id_valid, halted}); end
    for (int i = 0; i < 3; i++) begin
      step;
      checks++; if ({id_valid, id_ready, halted} !== 3'b001)
        begin errors++; $display("FAIL halt_sticky[%0d] got %b want 001", i, {id_valid, id_ready, halted}); end
    end
    flush = 1;
    step;
    flush = 0;
    checks++; if ({halted, id_ready} !== 2'b10) begin errors++; $display("FAIL halt_flush got %b want 10", {halted, id_ready}); end
    if_valid = 0; rst = 1;
    step;
    rst = 0; #1;
    checks++; if ({halted, id_ready} !== 2'b01) begin errors++; $display("FAIL halt_rst got %b want 01", {halted, id_ready}); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_backpressure;
    test_load_use;
    test_branch;
    test_back_to_back;
    test_halt_flush;
    test_halt;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
